// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate decode, regFile read, writeback
// bypass, load-use stall and the ID/EX pipeline register.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  input  logic [31:0]          if_instr,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 id_ready,
  input  logic                 flush,
  output logic                 rf_read_enable1,
  output logic                 rf_read_enable2,
  output logic [ADDR_SIZE-1:0] rf_read_addr1,
  output logic [ADDR_SIZE-1:0] rf_read_addr2,
  input  logic [XLEN-1:0]      rf_read_data1,
  input  logic [XLEN-1:0]      rf_read_data2,
  input  logic                 wb_write_enable,
  input  logic [ADDR_SIZE-1:0] wb_write_addr,
  input  logic [XLEN-1:0]      wb_write_data,
  input  logic                 ex_ready,
  output logic                 id_valid,
  output logic [XLEN-1:0]      id_pc,
  output logic [XLEN-1:0]      id_rs1_data,
  output logic [XLEN-1:0]      id_rs2_data,
  output logic [ADDR_SIZE-1:0] id_rs1_addr,
  output logic [ADDR_SIZE-1:0] id_rs2_addr,
  output logic [ADDR_SIZE-1:0] id_rd,
  output logic [XLEN-1:0]      id_imm,
  output logic [6:0]           id_opcode,
  output logic [2:0]           id_funct3,
  output logic                 id_funct7b5,
  output logic                 id_reg_write,
  output logic                 id_mem_read,
  output logic                 id_mem_write,
  output logic                 id_illegal
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic [6:0]  op;
  logic [31:0] ins;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

  assign ins = if_instr;
  assign op  = ins[6:0];

  assign i_imm = {{20{ins[31]}}, ins[31:20]};
  assign s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign b_imm = {{19{ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign u_imm = {ins[31:12], 12'b0};
  assign j_imm = {{11{ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  logic        legal, rs1_used, rs2_used, rd_wr;
  logic        is_ld, is_st;
  logic [31:0] imm;

  always_comb begin
    legal    = 1'b1;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    rd_wr    = 1'b0;
    is_ld    = 1'b0;
    is_st    = 1'b0;
    imm      = '0;
    unique case (op)
      OP_LUI, OP_AUIPC: begin
        rd_wr = 1'b1;
        imm   = u_imm;
      end
      OP_JAL: begin
        rd_wr = 1'b1;
        imm   = j_imm;
      end
      OP_JALR, OP_IMM: begin
        rs1_used = 1'b1;
        rd_wr    = 1'b1;
        imm      = i_imm;
      end
      OP_LD: begin
        rs1_used = 1'b1;
        rd_wr    = 1'b1;
        is_ld    = 1'b1;
        imm      = i_imm;
      end
      OP_ST: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        is_st    = 1'b1;
        imm      = s_imm;
      end
      OP_BR: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm      = b_imm;
      end
      OP_REG: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        rd_wr    = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  logic [ADDR_SIZE-1:0] rs1, rs2, rd;

  assign rs1 = rs1_used ? ADDR_SIZE'(ins[19:15]) : '0;
  assign rs2 = rs2_used ? ADDR_SIZE'(ins[24:20]) : '0;
  assign rd  = rd_wr ? ADDR_SIZE'(ins[11:7]) : '0;

  assign rf_read_enable1 = if_valid && rs1_used;
  assign rf_read_enable2 = if_valid && rs2_used;
  assign rf_read_addr1   = rs1;
  assign rf_read_addr2   = rs2;

  // unused sources already map to x0, so one zero test covers both
  logic [XLEN-1:0] op1, op2;

  always_comb begin
    op1 = rf_read_data1;
    op2 = rf_read_data2;
    if (rs1 == '0)
      op1 = '0;
    else if (wb_write_enable && wb_write_addr == rs1)
      op1 = wb_write_data;
    if (rs2 == '0)
      op2 = '0;
    else if (wb_write_enable && wb_write_addr == rs2)
      op2 = wb_write_data;
  end

  logic stall, transfer;

  assign stall = id_valid && id_mem_read && (id_rd != '0)
              && ((rs1_used && rs1 == id_rd)
               || (rs2_used && rs2 == id_rd));

  assign id_ready = !rst
                 && (flush || (!stall && (!id_valid || ex_ready)));

  assign transfer = if_valid && id_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_rs1_data  <= '0;
      id_rs2_data  <= '0;
      id_rs1_addr  <= '0;
      id_rs2_addr  <= '0;
      id_rd        <= '0;
      id_imm       <= '0;
      id_opcode    <= '0;
      id_funct3    <= '0;
      id_funct7b5  <= 1'b0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
      id_illegal   <= 1'b0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (transfer) begin
      id_valid     <= 1'b1;
      id_pc        <= if_pc;
      id_rs1_data  <= op1;
      id_rs2_data  <= op2;
      id_rs1_addr  <= rs1;
      id_rs2_addr  <= rs2;
      id_rd        <= rd;
      id_imm       <= XLEN'($signed(imm));
      id_opcode    <= op;
      id_funct3    <= ins[14:12];
      id_funct7b5  <= ins[30];
      id_reg_write <= rd != '0;
      id_mem_read  <= is_ld;
      id_mem_write <= is_st;
      id_illegal   <= !legal;
    end else if (!id_valid || ex_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one task per scenario, inline checks.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        flush;
  logic        rf_read_enable1, rf_read_enable2;
  logic [4:0]  rf_read_addr1, rf_read_addr2;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        wb_write_enable;
  logic [4:0]  wb_write_addr;
  logic [31:0] wb_write_data;
  logic        ex_ready;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7b5, id_reg_write, id_mem_read;
  logic        id_mem_write, id_illegal;

  int checks = 0;
  int failures = 0;

  decode_stage dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush),
    .rf_read_enable1(rf_read_enable1),
    .rf_read_enable2(rf_read_enable2),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_write_enable(wb_write_enable),
    .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
    .ex_ready(ex_ready), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd(id_rd), .id_imm(id_imm), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  // inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_valid = 1'b1;
    if_instr = 32'h00700293;
    if_pc = 32'h40;
    flush = 1'b0;
    rf_read_data1 = '0;
    rf_read_data2 = '0;
    wb_write_enable = 1'b0;
    wb_write_addr = '0;
    wb_write_data = '0;
    ex_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (id_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got %b exp 0", id_valid);
    end
    checks++;
    if (id_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got %b exp 0", id_ready);
    end
    checks++;
    if ({id_pc, id_imm, id_rd} !== '0) begin
      failures++;
      $display("FAIL reset_regs got %h %h %h exp 0",
               id_pc, id_imm, id_rd);
    end
    if_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    if_valid = 1'b1;
    if_instr = 32'h00700293;
    if_pc = 32'h100;
    rf_read_data1 = 32'h1234;
    ex_ready = 1'b1;
    #1;
    checks++;
    if ({id_ready, rf_read_enable1, rf_read_enable2}
        !== 3'b110) begin
      failures++;
      $display("FAIL addi_ports got %b%b%b exp 110",
               id_ready, rf_read_enable1, rf_read_enable2);
    end
    tick();
    if_valid = 1'b0;
    checks++;
    if (id_valid !== 1'b1 || id_rd !== 5'd5
        || id_imm !== 32'd7 || id_pc !== 32'h100) begin
      failures++;
      $display("FAIL addi_reg got v=%b rd=%0d imm=%h pc=%h exp 1 5 7 100",
               id_valid, id_rd, id_imm, id_pc);
    end
    checks++;
    if (id_rs1_data !== 32'd0 || id_reg_write !== 1'b1
        || id_opcode !== 7'h13) begin
      failures++;
      $display("FAIL addi_ctl got d=%h rw=%b op=%h exp 0 1 13",
               id_rs1_data, id_reg_write, id_opcode);
    end
    tick();
    checks++;
    if (id_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_valid got %b exp 0", id_valid);
    end
  endtask

  task automatic test_load_use();
    if_valid = 1'b1;
    if_instr = 32'h0000A183;
    if_pc = 32'h200;
    ex_ready = 1'b1;
    tick();
    checks++;
    if (id_valid !== 1'b1 || id_mem_read !== 1'b1 || id_rd !== 5'd3) begin
      failures++;
      $display("FAIL lw_reg got v=%b mr=%b rd=%0d exp 1 1 3",
               id_valid, id_mem_read, id_rd);
    end
    if_instr = 32'h00218233;
    if_pc = 32'h204;
    rf_read_data1 = 32'h30;
    rf_read_data2 = 32'h20;
    #1;
    checks++;
    if (id_ready !== 1'b0) begin
      failures++;
      $display("FAIL lu_stall got %b exp 0", id_ready);
    end
    tick();
    checks++;
    if (id_valid !== 1'b0 || id_ready !== 1'b1) begin
      failures++;
      $display("FAIL lu_bubble got v=%b r=%b exp 0 1",
               id_valid, id_ready);
    end
    tick();
    if_valid = 1'b0;
    checks++;
    if (id_valid !== 1'b1 || id_rs1_addr !== 5'd3
        || id_rs2_addr !== 5'd2 || id_rd !== 5'd4
        || id_pc !== 32'h204) begin
      failures++;
      $display("FAIL lu_add got v=%b a1=%0d a2=%0d rd=%0d pc=%h exp 1 3 2 4 204",
               id_valid, id_rs1_addr, id_rs2_addr, id_rd, id_pc);
    end
    checks++;
    if (id_rs1_data !== 32'h30 || id_rs2_data !== 32'h20) begin
      failures++;
      $display("FAIL lu_data got %h %h exp 30 20",
               id_rs1_data, id_rs2_data);
    end
    tick();
  endtask

  task automatic test_bypass();
    if_valid = 1'b1;
    if_instr = 32'h00208333;
    rf_read_data1 = 32'd5;
    rf_read_data2 = 32'd9;
    wb_write_enable = 1'b1;
    wb_write_addr = 5'd1;
    wb_write_data = 32'h55;
    tick();
    checks++;
    if (id_rs1_data !== 32'h55 || id_rs2_data !== 32'd9) begin
      failures++;
      $display("FAIL bypass got %h %h exp 55 9",
               id_rs1_data, id_rs2_data);
    end
    if_instr = 32'h00200333;
    wb_write_addr = 5'd0;
    wb_write_data = 32'h77;
    tick();
    checks++;
    if (id_rs1_data !== 32'd0 || id_rs2_data !== 32'd9) begin
      failures++;
      $display("FAIL bypass_x0 got %h %h exp 0 9",
               id_rs1_data, id_rs2_data);
    end
    if_valid = 1'b0;
    wb_write_enable = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    if_valid = 1'b1;
    if_instr = 32'h00700293;
    if_pc = 32'h300;
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    if_instr = 32'h00100393;
    if_pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (id_ready !== 1'b0 || id_valid !== 1'b1
          || id_pc !== 32'h300 || id_imm !== 32'd7) begin
        failures++;
        $display("FAIL hold_%0d got r=%b v=%b pc=%h imm=%h exp 0 1 300 7",
                 i, id_ready, id_valid, id_pc, id_imm);
      end
      tick();
    end
    ex_ready = 1'b1;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release got %b exp 1", id_ready);
    end
    tick();
    if_valid = 1'b0;
    checks++;
    if (id_pc !== 32'h304 || id_imm !== 32'd1 || id_rd !== 5'd7) begin
      failures++;
      $display("FAIL hold_next got pc=%h imm=%h rd=%0d exp 304 1 7",
               id_pc, id_imm, id_rd);
    end
    tick();
  endtask

  task automatic test_imm_formats();
    if_valid = 1'b1;
    if_instr = 32'hFE000CE3;
    #1;
    checks++;
    if (rf_read_enable2 !== 1'b1) begin
      failures++;
      $display("FAIL beq_ren2 got %b exp 1", rf_read_enable2);
    end
    tick();
    checks++;
    if (id_imm !== 32'hFFFFFFF8 || id_reg_write !== 1'b0
        || id_rd !== 5'd0) begin
      failures++;
      $display("FAIL beq got imm=%h rw=%b rd=%0d exp fffffff8 0 0",
               id_imm, id_reg_write, id_rd);
    end
    if_instr = 32'h0020A623;
    tick();
    checks++;
    if (id_imm !== 32'd12 || id_mem_write !== 1'b1
        || id_reg_write !== 1'b0 || id_funct3 !== 3'd2) begin
      failures++;
      $display("FAIL sw got imm=%h mw=%b rw=%b f3=%0d exp c 1 0 2",
               id_imm, id_mem_write, id_reg_write, id_funct3);
    end
    if_instr = 32'h123450B7;
    tick();
    checks++;
    if (id_imm !== 32'h12345000 || id_rd !== 5'd1) begin
      failures++;
      $display("FAIL lui got imm=%h rd=%0d exp 12345000 1",
               id_imm, id_rd);
    end
    if_instr = 32'hFFDFF0EF;
    tick();
    checks++;
    if (id_imm !== 32'hFFFFFFFC || id_rd !== 5'd1
        || id_rs1_addr !== 5'd0) begin
      failures++;
      $display("FAIL jal got imm=%h rd=%0d a1=%0d exp fffffffc 1 0",
               id_imm, id_rd, id_rs1_addr);
    end
    if_instr = 32'h40208333;
    tick();
    checks++;
    if (id_funct7b5 !== 1'b1 || id_imm !== 32'd0) begin
      failures++;
      $display("FAIL sub got f7b5=%b imm=%h exp 1 0",
               id_funct7b5, id_imm);
    end
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    if_valid = 1'b1;
    if_instr = 32'hFFFFFFFF;
    #1;
    checks++;
    if (rf_read_enable1 !== 1'b0 || rf_read_enable2 !== 1'b0) begin
      failures++;
      $display("FAIL ill_ren got %b%b exp 00",
               rf_read_enable1, rf_read_enable2);
    end
    tick();
    if_valid = 1'b0;
    checks++;
    if (id_illegal !== 1'b1 || id_reg_write !== 1'b0
        || id_rd !== 5'd0 || id_imm !== 32'd0
        || id_mem_read !== 1'b0 || id_mem_write !== 1'b0) begin
      failures++;
      $display("FAIL illegal got il=%b rw=%b rd=%0d imm=%h mr=%b mw=%b",
               id_illegal, id_reg_write, id_rd, id_imm,
               id_mem_read, id_mem_write);
    end
    tick();
  endtask

  task automatic test_flush();
    if_valid = 1'b1;
    if_instr = 32'h00700293;
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    flush = 1'b1;
    if_instr = 32'h00100393;
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_ready got %b exp 1", id_ready);
    end
    tick();
    flush = 1'b0;
    if_valid = 1'b0;
    checks++;
    if (id_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_valid got %b exp 0", id_valid);
    end
    tick();
    checks++;
    if (id_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_drop got %b exp 0", id_valid);
    end
    ex_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    if_valid = 1'b1;
    if_instr = 32'h00700293;
    tick();
    ex_ready = 1'b0;
    if_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (id_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_ready got %b exp 0", id_ready);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || id_imm !== 32'd0) begin
      failures++;
      $display("FAIL rstmid got v=%b imm=%h exp 0 0", id_valid, id_imm);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_bypass();
    test_hold();
    test_imm_formats();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I instruction-decode stage directly upstream of regFile; accepts fetched instructions and drives the regFile read ports.
- Decodes opcode, register fields and immediate, and registers operands and control into the ID/EX pipeline register.
- Owns the valid/ready handshake between fetch and execute, load-use stall detection, writeback bypass and flush.

Parameters:
- XLEN, 32, data/PC width
- ADDR_SIZE, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction PC
- id_ready  out  1  stage accepts if_instr this cycle
- flush  in  1  discard held and incoming instruction
- rf_read_enable1  out  1  to regFile read_enable1
- rf_read_enable2  out  1  to regFile read_enable2
- rf_read_addr1  out  ADDR_SIZE  rs1 address
- rf_read_addr2  out  ADDR_SIZE  rs2 address
- rf_read_data1  in  XLEN  regFile read_data1 (combinational)
- rf_read_data2  in  XLEN  regFile read_data2 (combinational)
- wb_write_enable  in  1  writeback writing this cycle
- wb_write_addr  in  ADDR_SIZE  writeback destination
- wb_write_data  in  XLEN  writeback data
- ex_ready  in  1  execute accepts the ID/EX register
- id_valid  out  1  ID/EX register holds a valid instruction
- id_pc  out  XLEN  registered PC
- id_rs1_data  out  XLEN  operand 1
- id_rs2_data  out  XLEN  operand 2
- id_rs1_addr  out  ADDR_SIZE  rs1 address (0 if unused), for EX forwarding
- id_rs2_addr  out  ADDR_SIZE  rs2 address (0 if unused)
- id_rd  out  ADDR_SIZE  destination (0 if no write)
- id_imm  out  XLEN  sign-extended immediate
- id_opcode  out  7  opcode
- id_funct3  out  3  funct3
- id_funct7b5  out  1  instr[30]
- id_reg_write  out  1  instruction writes rd (rd != 0)
- id_mem_read  out  1  load
- id_mem_write  out  1  store
- id_illegal  out  1  unsupported opcode

Behaviour:
- Reset: id_valid and every registered output = 0; id_ready = 0 while rst is high.
- Combinational decode of if_instr:
  - Register fields: rs1 = [19:15], rs2 = [24:20], rd = [11:7].
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - rd written by LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
- Immediates: I, S, B, U and J formats per RV32I; sign bit is always instr[31]; B and J have bit 0 = 0.
- Illegal opcode: id_illegal = 1, id_reg_write = id_mem_read = id_mem_write = 0, id_rd = 0, id_imm = 0.
- regFile read ports:
  - rf_read_enableN = if_valid && rsN used.
  - rf_read_addrN = field when used, else 0.
- Operand select, highest priority first:
  - rsN == 0 or unused -> 0.
  - wb_write_enable && wb_write_addr == rsN -> wb_write_data.
  - Otherwise rf_read_dataN.
- Load-use stall: id_valid && id_mem_read && id_rd != 0 && id_rd matches a used rs1/rs2 of if_instr.
- id_ready = !rst && !stall && (!id_valid || ex_ready).
- Transfer when if_valid && id_ready; ID/EX register loads all decoded fields and id_valid <= 1 at the next edge. Latency is 1 cycle.
- Hold: id_valid && !ex_ready -> all registered outputs unchanged.
- Bubble: stall && ex_ready -> id_valid <= 0 (other fields don't-care); the instruction is accepted the cycle after.
- Drain: ex_ready && !transfer && !stall -> id_valid <= 0.
- Flush (priority over everything except rst):
  - id_valid <= 0.
  - An incoming instruction in the same cycle is discarded.
  - id_ready is forced to 1 during flush so fetch drops its word.
- Reset mid-operation discards the held instruction.

Test Plan:
- ADDI x5,x0,7 (0x00700293), if_valid=1, ex_ready=1 -> next cycle id_valid=1, id_rd=5, id_imm=7, id_rs1_data=0, rf_read_enable2=0.
- LW x3,0(x1) followed by ADD x4,x3,x2 -> id_ready=0 for 1 cycle, one bubble (id_valid=0), then ADD issues with id_rs1_addr=3.
- ADD x6,x1,x2 with rf_read_data1=5 and wb writing x1=0x55 in the same cycle -> id_rs1_data=0x55.
- ex_ready=0 for 3 cycles with id_valid=1 -> outputs stable, id_ready=0; ex_ready=1 -> next instruction loaded.
- BEQ with offset -8 (0xFE000CE3) -> id_imm=0xFFFFFFF8, id_reg_write=0, id_rd=0.
- flush=1 while id_valid=1 and if_valid=1 -> id_valid=0 next cycle, id_ready=1, incoming instruction not captured.
- Opcode 0x7F -> id_illegal=1, id_reg_write=0.
